tnn_vote_accum: RTL and testbench
=================================

TNN_VOTE_ACCUM -- requirements
Module: tnn_vote_accum

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 7, number of output classes.
REQ-002 SHALL have parameter CNT_W, default 6, width of each per-class vote counter.
REQ-003 SHALL have parameter CLS_W, default 3, width of a class index; NUM_CLASSES SHALL be <= 2**CLS_W.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: a neuron result beat is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port in_bit, input, 1 bit: the 1-bit neuron decision (cgp_out).
REQ-009 SHALL have port in_class, input, CLS_W bits: the class this neuron votes for.
REQ-010 SHALL have port in_last, input, 1 bit: this is the final neuron of the current sample.
REQ-011 SHALL have port out_valid, output, 1 bit: a classification result is held.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-013 SHALL have port out_class, output, CLS_W bits: index of the winning class.
REQ-014 SHALL have port out_score, output, CNT_W bits: vote count of the winning class.

Function
REQ-015 SHALL implement the FSM states ACCUM, SCAN and HOLD; the reset state SHALL be ACCUM.
REQ-016 SHALL drive in_ready=1 only in ACCUM; a beat SHALL be accepted when in_valid && in_ready.
REQ-017 On an accepted beat with in_bit=1 and in_class<NUM_CLASSES, SHALL increment count[in_class] by 1, saturating at 2**CNT_W-1.
REQ-018 On an accepted beat with in_class>=NUM_CLASSES, SHALL leave all counts unchanged; in_last on that beat SHALL still be honoured.
REQ-019 On an accepted beat with in_last=1, SHALL apply that beat's vote and then transition ACCUM->SCAN.
REQ-020 SCAN SHALL examine one class per cycle, index 0 to NUM_CLASSES-1, and retain the running best class and score.
REQ-021 A class SHALL replace the running best only if its count is strictly greater, so ties resolve to the lowest index.
REQ-022 After exactly NUM_CLASSES SCAN cycles, SHALL enter HOLD with out_valid=1.
REQ-023 The latency from the accepted in_last beat to out_valid=1 SHALL be NUM_CLASSES+1 cycles.
REQ-024 In HOLD, out_class and out_score SHALL remain stable until out_valid && out_ready.
REQ-025 On the output handshake, SHALL clear all counts, deassert out_valid and return to ACCUM in the next cycle.
REQ-026 While out_valid=0, out_class and out_score SHALL read 0.
REQ-027 A sample with no positive votes SHALL yield out_class=0 and out_score=0.

Reset
REQ-028 When rst_n=0 at a clock edge, SHALL return to ACCUM, clear all counts and the running best, and set out_valid=0, out_class=0, out_score=0.
REQ-029 When rst_n=0 at a clock edge, in_ready SHALL be 1 in the following cycle.
REQ-030 A reset asserted during ACCUM, SCAN or HOLD SHALL abort the sample, and the partial result SHALL never be emitted.
REQ-031 A beat presented in the same cycle that rst_n=0 SHALL be discarded.

Structure
REQ-032 SHALL place the default values of NUM_CLASSES, CNT_W and CLS_W, and the FSM state enum, in a shared package tnn_vote_pkg.
REQ-033 SHALL implement each per-class counter as an instance of a sub-module tnn_sat_counter (increment, clear, saturate), generated NUM_CLASSES times.
REQ-034 SHALL keep the argmax scan in the top level, with no combinational path from in_* to out_*.

Verification
REQ-035 SHALL cover: 5 beats voting class 2 (in_bit=1), class 4 ×3, last beat class 4 in_bit=0 -> out_valid exactly 8 cycles after the last beat, out_class=2, out_score=5.
REQ-036 SHALL cover: classes 1 and 3 each receive 4 votes -> out_class=1, out_score=4 (tie goes to the lowest index).
REQ-037 SHALL cover: 70 votes to class 6 with CNT_W=6 -> out_score=63 (saturation), out_class=6.
REQ-038 SHALL cover: out_ready held 0 for 10 cycles in HOLD -> in_ready=0 and outputs stable throughout; after the handshake, counts read 0 for the next sample.
REQ-039 SHALL cover: in_class=7 with in_last=1 as the only beat -> out_class=0, out_score=0, and out_valid asserts on schedule.
REQ-040 SHALL cover: rst_n=0 for 1 cycle mid-SCAN -> out_valid never asserts for that sample; the next sample of 2 votes to class 0 -> out_score=2.

Source files
------------

// File: rtl/tnn_vote_pkg.sv
// rtl/tnn_vote_pkg.sv - shared defaults and FSM state type for the TNN vote accumulator
//
// Purpose: default geometry of the vote accumulator and the encoding of its
// control states, shared by the top level and any helper logic.
// Ports: none (package).

package tnn_vote_pkg;

  localparam int NUM_CLASSES_DEF = 7;
  localparam int CNT_W_DEF       = 6;
  localparam int CLS_W_DEF       = 3;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_HOLD  = 2'd2
  } vote_state_t;

endpackage

// File: rtl/tnn_sat_counter.sv
// rtl/tnn_sat_counter.sv - per-class saturating vote counter
//
// Purpose: counts votes for one class; increments by one, sticks at all-ones,
// and clears on reset or on an explicit clear pulse.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset, clears the count
//   clr   - synchronous clear (result consumed)
//   inc   - add one vote this cycle
//   count - current vote count

module tnn_sat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tnn_vote_accum.sv
// rtl/tnn_vote_accum.sv - TNN per-class vote accumulator with argmax output
//
// Purpose: accumulates 1-bit neuron votes into per-class saturating counters
// for one sample, then scans the counters one class per cycle to find the
// winning class (ties go to the lowest index) and holds the result until the
// consumer takes it.
// Ports:
//   clk, rst_n        - clock and synchronous active-low reset
//   in_valid/in_ready - neuron beat handshake (ready only while accumulating)
//   in_bit            - neuron decision; 1 casts a vote
//   in_class          - class the neuron votes for (out-of-range: no vote)
//   in_last           - final neuron of the sample
//   out_valid/out_ready - result handshake
//   out_class         - winning class index (0 while out_valid=0)
//   out_score         - vote count of the winner (0 while out_valid=0)

module tnn_vote_accum
  import tnn_vote_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int CLS_W       = CLS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [CLS_W-1:0] in_class,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CLS_W-1:0] out_class,
  output logic [CNT_W-1:0] out_score
);

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

  vote_state_t state_q;
  vote_state_t state_d;

  logic             accept;
  logic             take;
  logic             cnt_clr;
  logic [CNT_W-1:0] counts [NUM_CLASSES];
  logic [CNT_W-1:0] scan_count;

  logic [CLS_W-1:0] scan_idx;
  logic [CLS_W-1:0] best_class;
  logic [CNT_W-1:0] best_score;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign cnt_clr   = take;

  // Out-of-range classes match no counter, so they fall through as no-vote
  // while in_last on the same beat still ends the sample.
  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
    tnn_sat_counter #(
      .W(CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (accept && in_bit && (in_class == CLS_W'(i))),
      .count (counts[i])
    );
  end

  always_comb begin
    scan_count = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx == CLS_W'(i)) begin
        scan_count = counts[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (accept && in_last)     state_d = ST_SCAN;
      ST_SCAN:  if (scan_idx == LAST_IDX)  state_d = ST_HOLD;
      ST_HOLD:  if (out_ready)             state_d = ST_ACCUM;
      default:                             state_d = ST_ACCUM;
    endcase
  end

  // Running best starts at class 0 / score 0 so that an all-zero sample
  // resolves to class 0; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_idx   <= '0;
      best_class <= '0;
      best_score <= '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept && in_last) begin
            scan_idx   <= '0;
            best_class <= '0;
            best_score <= '0;
          end
        end
        ST_SCAN: begin
          if (scan_count > best_score) begin
            best_class <= scan_idx;
            best_score <= scan_count;
          end
          scan_idx <= scan_idx + 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) begin
            best_class <= '0;
            best_score <= '0;
          end
        end
        default: begin
          scan_idx <= '0;
        end
      endcase
    end
  end

  assign out_class = out_valid ? best_class : '0;
  assign out_score = out_valid ? best_score : '0;

endmodule

// File: tb/tb_tnn_vote_accum.sv
// tb/tb_tnn_vote_accum.sv - directed self-checking bench for tnn_vote_accum

module tb_tnn_vote_accum;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic [2:0] in_class;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_class;
  logic [5:0] out_score;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tnn_vote_accum #(
    .NUM_CLASSES(7),
    .CNT_W      (6),
    .CLS_W      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_class  (in_class),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input bit b, input int cls, input bit last);
    in_valid = 1'b1;
    in_bit   = b;
    in_class = 3'(cls);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the edge that accepted in_last (that beat's cycle is 0).
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_after_take"}, out_valid, 0);
    check({tag, "_ready_after_take"}, in_ready, 1);
    check({tag, "_class_after_take"}, out_class, 0);
  endtask

  task automatic expect_result(input string tag, input int cls, input int score);
    int lat;
    wait_out(lat);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_class"}, out_class, cls);
    check({tag, "_score"}, out_score, score);
    take_result(tag);
  endtask

  initial begin
    int  lat;
    bit  seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_class  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    // a vote for class 2 presented during reset must be discarded
    in_valid = 1'b1; in_bit = 1'b1; in_class = 3'd2;
    tick();
    in_valid = 1'b0; in_bit = 1'b0;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_score", out_score, 0);

    // five votes to class 2, three to class 4, final beat class 4 without a vote
    for (int i = 0; i < 5; i++) send_beat(1'b1, 2, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(1'b1, 4, 1'b0);
    send_beat(1'b0, 4, 1'b1);
    expect_result("basic", 2, 5);

    // tie between classes 1 and 3 resolves to the lower index
    for (int i = 0; i < 4; i++) begin
      send_beat(1'b1, 3, 1'b0);
      send_beat(1'b1, 1, i == 3);
    end
    expect_result("tie", 1, 4);

    // 70 votes saturate a 6-bit counter at 63
    for (int i = 0; i < 70; i++) send_beat(1'b1, 6, i == 69);
    expect_result("sat", 6, 63);

    // stalled output: stable result, no beats accepted
    for (int i = 0; i < 3; i++) send_beat(1'b1, 5, i == 2);
    wait_out(lat);
    check("stall_latency", lat, 8);
    in_valid = 1'b1; in_bit = 1'b1; in_class = 3'd0;
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_class", out_class, 5);
      check("stall_out_score", out_score, 3);
      tick();
    end
    in_valid = 1'b0; in_bit = 1'b0;
    take_result("stall");
    // counts cleared: one more vote to class 5 scores 1, not 4
    send_beat(1'b1, 5, 1'b1);
    expect_result("cleared", 5, 1);

    // out-of-range class as the only beat still ends the sample
    send_beat(1'b1, 7, 1'b1);
    expect_result("oob", 0, 0);

    // reset mid-scan aborts the sample
    for (int i = 0; i < 3; i++) send_beat(1'b1, 4, i == 2);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_valid", seen, 0);
    send_beat(1'b1, 0, 1'b0);
    send_beat(1'b1, 0, 1'b1);
    expect_result("after_abort", 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
